riscv_core_dcache_write_buffer: RTL and testbench

//  Write-through store buffer downstream of the D-cache controller. Accepts {addr,data} entries pushed on write hits,

---
 rtl/riscv_core_dcache_write_buffer.sv | 152 +++++++++++++++
 tb/tb_riscv_core_dcache_write_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_dcache_write_buffer.sv
// Write-through store buffer: queues {addr,data} entries from the D-cache controller
// and drains them in push order, one single-beat AXI4 write (AW/W/B) at a time.
module riscv_core_dcache_write_buffer #(
   parameter int DEPTH            = 4,
   parameter int ADDR_WIDTH       = 64,
   parameter int CORE_DATA_WIDTH  = 64,
   parameter int FIFO_ENTRY_WIDTH = ADDR_WIDTH + CORE_DATA_WIDTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_fifo_push,
   input  logic [FIFO_ENTRY_WIDTH-1:0]   i_fifo_entry,
   output logic                          o_fifo_full,
   output logic                          o_fifo_empty,
   output logic [ADDR_WIDTH-1:0]         o_awaddr,
   output logic                          o_awvalid,
   input  logic                          i_awready,
   output logic [2:0]                    o_awsize,
   output logic [CORE_DATA_WIDTH-1:0]    o_wdata,
   output logic [CORE_DATA_WIDTH/8-1:0]  o_wstrb,
   output logic                          o_wlast,
   output logic                          o_wvalid,
   input  logic                          i_wready,
   input  logic                          i_bvalid,
   input  logic [1:0]                    i_bresp,
   output logic                          o_bready,
   output logic                          o_bus_err,
   output logic                          o_push_drop
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

   logic [FIFO_ENTRY_WIDTH-1:0] mem [DEPTH];
   logic [FIFO_ENTRY_WIDTH-1:0] head;
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic [PTR_W:0]              count;
   logic [PTR_W:0]              count_next;
   state_t                      state;
   state_t                      state_next;
   logic                        awvalid_next;
   logic                        wvalid_next;
   logic                        bready_next;
   logic                        push_ok;
   logic                        pop;

   assign o_fifo_full  = (count == (PTR_W+1)'(DEPTH));
   assign o_fifo_empty = (count == '0) && (state == IDLE);
   assign push_ok      = i_fifo_push && !o_fifo_full;
   assign pop          = (state == RESP) && i_bvalid && o_bready;

   // The head slot cannot be overwritten while occupied, so AW/W payload is stable until the pop
   assign head     = mem[rd_ptr];
   assign o_awaddr = head[FIFO_ENTRY_WIDTH-1:CORE_DATA_WIDTH] & ~ADDR_WIDTH'(7);
   assign o_wdata  = head[CORE_DATA_WIDTH-1:0];
   assign o_awsize = 3'b011;
   assign o_wstrb  = '1;
   assign o_wlast  = o_wvalid;

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_fifo_entry;
      end
   end

   always_comb begin
      count_next = count;
      case ({push_ok, pop})
         2'b10:   count_next = count + (PTR_W+1)'(1);
         2'b01:   count_next = count - (PTR_W+1)'(1);
         default: count_next = count;
      endcase
   end

   // Looking at count_next lets an entry pushed this cycle start its write next cycle,
   // and lets RESP chain straight into the next SEND without an IDLE bubble
   always_comb begin
      state_next   = state;
      awvalid_next = o_awvalid;
      wvalid_next  = o_wvalid;
      bready_next  = o_bready;
      case (state)
         IDLE: begin
            if (count_next != '0) begin
               state_next   = SEND;
               awvalid_next = 1'b1;
               wvalid_next  = 1'b1;
            end
         end
         SEND: begin
            awvalid_next = o_awvalid && !i_awready;
            wvalid_next  = o_wvalid && !i_wready;
            if (!awvalid_next && !wvalid_next) begin
               state_next  = RESP;
               bready_next = 1'b1;
            end
         end
         RESP: begin
            if (pop) begin
               bready_next = 1'b0;
               if (count_next != '0) begin
                  state_next   = SEND;
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next   = IDLE;
            awvalid_next = 1'b0;
            wvalid_next  = 1'b0;
            bready_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_awvalid   <= 1'b0;
         o_wvalid    <= 1'b0;
         o_bready    <= 1'b0;
         o_bus_err   <= 1'b0;
         o_push_drop <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         o_awvalid   <= awvalid_next;
         o_wvalid    <= wvalid_next;
         o_bready    <= bready_next;
         o_push_drop <= i_fifo_push && o_fifo_full;
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Errored writes are still retired; the flag stays up until reset
         if (pop && (i_bresp != 2'b00)) begin
            o_bus_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_core_dcache_write_buffer.sv
// Self-checking bench for riscv_core_dcache_write_buffer: table-driven single writes
// plus hand-written full/drop, skewed handshake, streaming and error/reset sequences.
module tb_riscv_core_dcache_write_buffer;

   logic         i_clk;
   logic         i_rst_n;
   logic         i_fifo_push;
   logic [127:0] i_fifo_entry;
   logic         o_fifo_full;
   logic         o_fifo_empty;
   logic [63:0]  o_awaddr;
   logic         o_awvalid;
   logic         i_awready;
   logic [2:0]   o_awsize;
   logic [63:0]  o_wdata;
   logic [7:0]   o_wstrb;
   logic         o_wlast;
   logic         o_wvalid;
   logic         i_wready;
   logic         i_bvalid;
   logic [1:0]   i_bresp;
   logic         o_bready;
   logic         o_bus_err;
   logic         o_push_drop;

   int n_compared   = 0;
   int n_mismatched = 0;
   logic exp_bus_err;

   logic [63:0] exp_addr_q[$];
   logic [63:0] exp_data_q[$];
   logic [63:0] got_addr_q[$];
   logic [63:0] got_data_q[$];
   logic [1:0]  bresp_plan [64];

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [63:0] exp_awaddr;
   } vec_t;

   vec_t vecs [5];

   riscv_core_dcache_write_buffer #(
      .DEPTH(4), .ADDR_WIDTH(64), .CORE_DATA_WIDTH(64), .FIFO_ENTRY_WIDTH(128)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_fifo_push(i_fifo_push), .i_fifo_entry(i_fifo_entry),
      .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty),
      .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awsize(o_awsize),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
      .i_wready(i_wready), .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
      .o_bus_err(o_bus_err), .o_push_drop(o_push_drop)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset;
      i_rst_n      = 1'b0;
      i_fifo_push  = 1'b0;
      i_fifo_entry = '0;
      i_awready    = 1'b0;
      i_wready     = 1'b0;
      i_bvalid     = 1'b0;
      i_bresp      = 2'b00;
      exp_bus_err  = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      tick();
   endtask

   // Drive a single push for one cycle; returns 1 ns after the sampling edge
   task automatic apply_stimulus(input logic [63:0] addr, input logic [63:0] data);
      i_fifo_push  = 1'b1;
      i_fifo_entry = {addr, data};
      tick();
      i_fifo_push  = 1'b0;
   endtask

   task automatic clear_streams;
      exp_addr_q.delete();
      exp_data_q.delete();
      got_addr_q.delete();
      got_data_q.delete();
      for (int i = 0; i < 64; i++) bresp_plan[i] = 2'b00;
   endtask

   task automatic pusher(input int n, input bit gaps, input logic [63:0] base);
      int i = 0;
      int cyc = 0;
      logic [63:0] addr;
      logic [63:0] data;
      while (i < n && cyc < 2000) begin
         if (!o_fifo_full && (!gaps || $urandom_range(0, 3) != 0)) begin
            addr = base + 64'(i) * 64'd8;
            data = {$urandom, $urandom};
            i_fifo_push  = 1'b1;
            i_fifo_entry = {addr, data};
            exp_addr_q.push_back(addr);
            exp_data_q.push_back(data);
            i++;
         end else begin
            i_fifo_push = 1'b0;
         end
         tick();
         cyc++;
      end
      i_fifo_push = 1'b0;
      check_output("pusher_timeout", 128'(i), 128'(n));
   endtask

   // AXI slave model: optional random ready/bvalid stalls, records accepted AW/W payloads
   task automatic slave_run(input int n_writes, input int max_cycles, input bit stall);
      int done_cnt = 0;
      int cyc = 0;
      bit aw_seen = 0;
      bit w_seen = 0;
      bit aw_hs, w_hs, b_hs, prev_awv, prev_wv;
      logic [63:0] addr_cap;
      logic [63:0] data_cap;
      while (done_cnt < n_writes && cyc < max_cycles) begin
         i_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         i_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (aw_seen && w_seen && !i_bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
            i_bvalid = 1'b1;
            i_bresp  = bresp_plan[done_cnt];
         end
         aw_hs    = o_awvalid && i_awready;
         w_hs     = o_wvalid && i_wready;
         b_hs     = i_bvalid && o_bready;
         prev_awv = o_awvalid;
         prev_wv  = o_wvalid;
         addr_cap = o_awaddr;
         data_cap = o_wdata;
         tick();
         cyc++;
         if (aw_hs) begin
            got_addr_q.push_back(addr_cap);
            aw_seen = 1;
         end
         if (w_hs) begin
            got_data_q.push_back(data_cap);
            w_seen = 1;
         end
         if (prev_awv && !aw_hs) check_output("awvalid_hold", o_awvalid, 1);
         if (prev_wv && !w_hs) check_output("wvalid_hold", o_wvalid, 1);
         if (b_hs) begin
            if (i_bresp != 2'b00) exp_bus_err = 1'b1;
            i_bvalid = 1'b0;
            i_bresp  = 2'b00;
            aw_seen  = 0;
            w_seen   = 0;
            done_cnt++;
            check_output("bus_err_after_b", o_bus_err, exp_bus_err);
         end
      end
      i_awready = 1'b0;
      i_wready  = 1'b0;
      check_output("slave_timeout", 128'(done_cnt), 128'(n_writes));
   endtask

   task automatic compare_streams(input int n);
      check_output("aw_count", 128'(got_addr_q.size()), 128'(n));
      check_output("w_count", 128'(got_data_q.size()), 128'(n));
      for (int i = 0; i < n && i < got_addr_q.size() && i < exp_addr_q.size(); i++)
         check_output($sformatf("stream_addr[%0d]", i), got_addr_q[i], exp_addr_q[i] & ~64'h7);
      for (int i = 0; i < n && i < got_data_q.size() && i < exp_data_q.size(); i++)
         check_output($sformatf("stream_data[%0d]", i), got_data_q[i], exp_data_q[i]);
   endtask

   initial begin
      vecs[0] = '{64'h0000_0000_1000_0007, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1000_0000};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFF8};
      vecs[2] = '{64'h8000_0000_0000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0008};
      vecs[3] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
      vecs[4] = '{64'h1234_5678_9ABC_DEF3, 64'hA5A5_5A5A_A5A5_5A5A, 64'h1234_5678_9ABC_DEF0};

      clear_streams();
      do_reset();
      $display("[TB] reset state");
      check_output("rst_empty", o_fifo_empty, 1);
      check_output("rst_full", o_fifo_full, 0);
      check_output("rst_awvalid", o_awvalid, 0);
      check_output("rst_wvalid", o_wvalid, 0);
      check_output("rst_bready", o_bready, 0);
      check_output("rst_bus_err", o_bus_err, 0);
      check_output("rst_push_drop", o_push_drop, 0);

      $display("[TB] single-write vector table");
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].addr, vecs[i].data);
         check_output($sformatf("v%0d_awvalid", i), o_awvalid, 1);
         check_output($sformatf("v%0d_wvalid", i), o_wvalid, 1);
         check_output($sformatf("v%0d_awaddr", i), o_awaddr, vecs[i].exp_awaddr);
         check_output($sformatf("v%0d_wdata", i), o_wdata, vecs[i].data);
         check_output($sformatf("v%0d_wstrb", i), o_wstrb, 8'hFF);
         check_output($sformatf("v%0d_awsize", i), o_awsize, 3'b011);
         check_output($sformatf("v%0d_wlast", i), o_wlast, 1);
         check_output($sformatf("v%0d_empty_busy", i), o_fifo_empty, 0);
         i_awready = 1'b1;
         i_wready  = 1'b1;
         tick();
         i_awready = 1'b0;
         i_wready  = 1'b0;
         check_output($sformatf("v%0d_awvalid_done", i), o_awvalid, 0);
         check_output($sformatf("v%0d_wvalid_done", i), o_wvalid, 0);
         check_output($sformatf("v%0d_bready", i), o_bready, 1);
         i_bvalid = 1'b1;
         i_bresp  = 2'b00;
         tick();
         i_bvalid = 1'b0;
         check_output($sformatf("v%0d_bready_off", i), o_bready, 0);
         check_output($sformatf("v%0d_empty", i), o_fifo_empty, 1);
         check_output($sformatf("v%0d_bus_err", i), o_bus_err, 0);
      end

      $display("[TB] fill to full, drop on overflow");
      clear_streams();
      for (int k = 0; k < 4; k++) begin
         exp_addr_q.push_back(64'h2000_0000 + 64'(k) * 64'h40);
         exp_data_q.push_back(64'h1111_0000_0000_0000 + 64'(k));
         apply_stimulus(exp_addr_q[k], exp_data_q[k]);
         if (k == 2) check_output("full_at_3", o_fifo_full, 0);
      end
      check_output("full_at_4", o_fifo_full, 1);
      check_output("drop_before", o_push_drop, 0);
      apply_stimulus(64'h3333_0000, 64'hBAD0_BAD0_BAD0_BAD0);
      check_output("drop_pulse", o_push_drop, 1);
      check_output("full_after_drop", o_fifo_full, 1);
      tick();
      check_output("drop_pulse_end", o_push_drop, 0);
      slave_run(4, 200, 0);
      compare_streams(4);
      tick();
      check_output("drained_empty", o_fifo_empty, 1);

      $display("[TB] skewed AW/W handshakes");
      apply_stimulus(64'h4000_0010, 64'hCAFE_F00D_0000_0001);
      check_output("skew_valids", {o_awvalid, o_wvalid}, 2'b11);
      i_wready = 1'b1;
      tick();
      i_wready = 1'b0;
      check_output("skew_c1_wvalid", o_wvalid, 0);
      check_output("skew_c1_awvalid", o_awvalid, 1);
      check_output("skew_c1_bready", o_bready, 0);
      tick();
      tick();
      check_output("skew_c3_awvalid", o_awvalid, 1);
      check_output("skew_c3_bready", o_bready, 0);
      check_output("skew_c3_awaddr", o_awaddr, 64'h4000_0010);
      i_awready = 1'b1;
      tick();
      i_awready = 1'b0;
      check_output("skew_c4_awvalid", o_awvalid, 0);
      check_output("skew_c4_bready", o_bready, 1);
      i_bvalid = 1'b1;
      tick();
      i_bvalid = 1'b0;
      check_output("skew_empty", o_fifo_empty, 1);

      $display("[TB] streaming with random stalls");
      clear_streams();
      fork
         pusher(24, 1, 64'hC000_0000);
         slave_run(24, 3000, 1);
      join
      compare_streams(24);
      check_output("stream_empty", o_fifo_empty, 1);
      check_output("stream_bus_err", o_bus_err, 0);

      $display("[TB] error response on second write");
      clear_streams();
      bresp_plan[1] = 2'b10;
      fork
         pusher(3, 0, 64'hE000_0100);
         slave_run(3, 300, 0);
      join
      compare_streams(3);
      tick();
      tick();
      check_output("err_sticky", o_bus_err, 1);
      check_output("err_empty", o_fifo_empty, 1);

      $display("[TB] reset during SEND");
      apply_stimulus(64'h5000_0000, 64'h5555_5555_5555_5555);
      check_output("pre_rst_awvalid", o_awvalid, 1);
      i_rst_n = 1'b0;
      #2;
      check_output("mid_rst_awvalid", o_awvalid, 0);
      check_output("mid_rst_wvalid", o_wvalid, 0);
      check_output("mid_rst_bready", o_bready, 0);
      check_output("mid_rst_empty", o_fifo_empty, 1);
      check_output("mid_rst_full", o_fifo_full, 0);
      check_output("mid_rst_bus_err", o_bus_err, 0);
      tick();
      i_rst_n = 1'b1;
      tick();
      tick();
      check_output("post_rst_awvalid", o_awvalid, 0);
      check_output("post_rst_empty", o_fifo_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
